uart_rx_os16: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_os16_if.sv | 31 +++
 rtl/uart_rx_os16_sync_2ff.sv | 30 +++
 rtl/uart_rx_os16.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_os16.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : UART shared state encoding and oversampling constants (rx/tx).
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int OS_RATE    = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_os16_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_rx_os16_if
// Brief     : Serial line, oversampling tick and received-word outputs.
//             UART_RX_PARITY_EN adds the parity_err signal.
// Revision  : 1.0
// ============================================================================
interface uart_rx_os16_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
    logic            busy;
`ifdef UART_RX_PARITY_EN
    logic            parity_err;

    modport master (output rx, s_tick,
                    input  dout, rx_done_tick, frame_err, busy, parity_err);
    modport slave  (input  rx, s_tick,
                    output dout, rx_done_tick, frame_err, busy, parity_err);
`else
    modport master (output rx, s_tick,
                    input  dout, rx_done_tick, frame_err, busy);
    modport slave  (input  rx, s_tick,
                    output dout, rx_done_tick, frame_err, busy);
`endif
endinterface
`default_nettype wire

// File: rtl/uart_rx_os16_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Generic two-flop synchroniser for asynchronous single-bit inputs.
// Revision : 1.0
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_d,
    output logic      o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/uart_rx_os16.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os16
// Brief    : UART receiver on a 16x oversampling tick; mid-cell sampling,
//            stop-bit check, one-clk done strobe.
// Options  : UART_RX_PARITY_EN adds a parity cell, PAR_ODD and parity_err.
// Revision : 1.0
// ============================================================================
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PAR_ODD = 1'b0
`endif
) (
    input  wire logic     clk,
    input  wire logic     reset,
    uart_rx_os16_if.slave bus
);
    localparam int SW = (SB_TICK > OS_RATE) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] c_S_MID  = SW'(MID_SAMPLE);
    localparam logic [SW-1:0] c_S_CELL = SW'(OS_RATE - 1);
    localparam logic [SW-1:0] c_S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] c_N_LAST = NW'(DBIT - 1);

    uart_state_t     r_state, w_state;
    logic [SW-1:0]   r_s, w_s;
    logic [NW-1:0]   r_n, w_n;
    logic [DBIT-1:0] r_shreg, w_shreg;
    logic [DBIT-1:0] r_dout, w_dout;
    logic            r_done, w_done;
    logic            r_ferr, w_ferr;
    logic            w_rx_s;
`ifdef UART_RX_PARITY_EN
    logic            r_par_bit, w_par_bit;
    logic            r_perr, w_perr;
`endif

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shreg <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state <= w_state;
            r_s     <= w_s;
            r_n     <= w_n;
            r_shreg <= w_shreg;
            r_dout  <= w_dout;
            r_done  <= w_done;
            r_ferr  <= w_ferr;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= w_par_bit;
            r_perr    <= w_perr;
`endif
        end
    end

    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_n     = r_n;
        w_shreg = r_shreg;
        w_dout  = r_dout;
        w_done  = 1'b0;
        w_ferr  = r_ferr;
`ifdef UART_RX_PARITY_EN
        w_par_bit = r_par_bit;
        w_perr    = r_perr;
`endif
        case (r_state)
            // Start detection is not gated by s_tick so the cell phase is
            // anchored to the falling edge rather than the next tick.
            IDLE: begin
                if (!w_rx_s) begin
                    w_state = START;
                    w_s     = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (r_s == c_S_MID) begin
                        if (!w_rx_s) begin
                            w_state = DATA;
                            w_s     = '0;
                            w_n     = '0;
                        end else begin
                            w_state = IDLE;
                        end
                    end else begin
                        w_s = r_s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (r_s == c_S_CELL) begin
                        w_s     = '0;
                        w_shreg = {w_rx_s, r_shreg[DBIT-1:1]};
                        if (r_n == c_N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state = PARITY;
`else
                            w_state = STOP;
`endif
                        end else begin
                            w_n = r_n + 1'b1;
                        end
                    end else begin
                        w_s = r_s + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bus.s_tick) begin
                    if (r_s == c_S_CELL) begin
                        w_s       = '0;
                        w_par_bit = w_rx_s;
                        w_state   = STOP;
                    end else begin
                        w_s = r_s + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (bus.s_tick) begin
                    if (r_s == c_S_STOP) begin
                        w_dout  = r_shreg;
                        w_ferr  = ~w_rx_s;
                        w_done  = 1'b1;
                        w_state = IDLE;
`ifdef UART_RX_PARITY_EN
                        w_perr  = ((^r_shreg) ^ r_par_bit) != PAR_ODD;
`endif
                    end else begin
                        w_s = r_s + 1'b1;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.dout         = r_dout;
    assign bus.rx_done_tick = r_done;
    assign bus.frame_err    = r_ferr;
    assign bus.busy         = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = r_perr;
`endif
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os16
// Brief    : Self-checking bench for uart_rx_os16 (frame-level reference model).
//            Honours UART_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_os16;
    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB      = DBIT + 3;
    localparam bit PAR_ODD = 1'b0;
`else
    localparam int NB      = DBIT + 2;
`endif
    localparam int L = NB * 16;

    typedef struct packed {
        logic [DBIT-1:0] d;
        logic            fe;
        logic            pe;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   tick_p      = 1;
    int   tick_cnt    = 0;
    logic [DBIT-1:0] last_dout = '0;
    rec_t got_q[$];
    rec_t exp_q[$];

    uart_rx_os16_if #(.DBIT(DBIT)) bus ();

    uart_rx_os16 #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK)
`ifdef UART_RX_PARITY_EN
        ,
        .PAR_ODD (PAR_ODD)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.s_tick = 1'b1;
        forever begin
            @(negedge clk);
            if (tick_cnt >= tick_p - 1) begin
                tick_cnt   = 0;
                bus.s_tick = 1'b1;
            end else begin
                tick_cnt   = tick_cnt + 1;
                bus.s_tick = 1'b0;
            end
        end
    end

    function automatic logic obs_perr();
`ifdef UART_RX_PARITY_EN
        return bus.parity_err;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rx_done_tick === 1'b1) begin
                r.d  = bus.dout;
                r.fe = bus.frame_err;
                r.pe = obs_perr();
                got_q.push_back(r);
            end
        end
    end

    function automatic int ones_of(input logic [DBIT-1:0] d);
        int c = 0;
        for (int i = 0; i < DBIT; i++) c += int'(d[i]);
        return c;
    endfunction

    function automatic logic par_bit_for(input logic [DBIT-1:0] d, input bit flip);
`ifdef UART_RX_PARITY_EN
        return logic'(((ones_of(d) + int'(PAR_ODD)) % 2 != 0) ^ flip);
`else
        return logic'(flip);
`endif
    endfunction

    function automatic logic model_perr(input logic [DBIT-1:0] d, input logic pbit);
`ifdef UART_RX_PARITY_EN
        return logic'(((ones_of(d) + int'(pbit)) % 2) != int'(PAR_ODD));
`else
        return logic'(pbit & 1'b0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [DBIT-1:0] d, input logic fe, input logic pe);
        rec_t r;
        r.d  = d;
        r.fe = fe;
        r.pe = pe;
        exp_q.push_back(r);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame tick by tick; inner edges may be skewed by up to
    // max_skew ticks. rst_tick >= 0 aborts the frame with a reset pulse.
    task automatic send_frame(input logic [DBIT-1:0] d, input logic stop_lvl,
                              input bit flip, input int max_skew, input int rst_tick);
        logic bits[NB];
        int   edge_t[NB];
        int   idx;
        logic pbit;
        pbit    = par_bit_for(d, flip);
        bits[0] = 1'b0;
        for (int i = 0; i < DBIT; i++) bits[i+1] = d[i];
`ifdef UART_RX_PARITY_EN
        bits[DBIT+1] = pbit;
`endif
        bits[NB-1] = stop_lvl;
        edge_t[0]  = 0;
        for (int k = 1; k < NB; k++)
            edge_t[k] = 16 * k + int'($urandom_range(2 * max_skew)) - max_skew;
        for (int t = 0; t < L; t++) begin
            if (t == rst_tick) begin
                reset  = 1'b1;
                bus.rx = 1'b1;
                #1;
                chk("rst dout", 32'(bus.dout), 32'h0);
                chk("rst frame_err", 32'(bus.frame_err), 32'h0);
                chk("rst done", 32'(bus.rx_done_tick), 32'h0);
                chk("rst busy", 32'(bus.busy), 32'h0);
                chk("rst perr", 32'(obs_perr()), 32'h0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            idx = 0;
            for (int k = 1; k < NB; k++) if (t >= edge_t[k]) idx = k;
            bus.rx = bits[idx];
            repeat (tick_p) @(negedge clk);
        end
        push_exp(d, ~stop_lvl, model_perr(d, pbit));
    endtask

    task automatic check_frames(input string tag);
        chk({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, " dout"}, 32'(got_q[i].d), 32'(exp_q[i].d));
            chk({tag, " frame_err"}, 32'(got_q[i].fe), 32'(exp_q[i].fe));
            chk({tag, " parity_err"}, 32'(got_q[i].pe), 32'(exp_q[i].pe));
        end
        if (exp_q.size() > 0) last_dout = exp_q[exp_q.size()-1].d;
        chk({tag, " dout held"}, 32'(bus.dout), 32'(last_dout));
        chk({tag, " busy idle"}, 32'(bus.busy), 32'h0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [DBIT-1:0] rd;
        logic            rs;
        bit              rf;
        reset  = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset dout", 32'(bus.dout), 32'h0);
        chk("reset frame_err", 32'(bus.frame_err), 32'h0);
        chk("reset done", 32'(bus.rx_done_tick), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        chk("reset perr", 32'(obs_perr()), 32'h0);
        reset = 1'b0;
        idle(4);

        send_frame(8'hA5, 1'b1, 1'b0, 0, -1);
        idle(20);
        check_frames("a5");

        send_frame(8'h00, 1'b1, 1'b0, 0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, 0, -1);
        idle(20);
        check_frames("b2b");

        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check_frames("glitch");

        send_frame(8'h3C, 1'b0, 1'b0, 0, -1);
        idle(30);
        check_frames("badstop");
        send_frame(8'h3C, 1'b1, 1'b0, 0, -1);
        idle(20);
        check_frames("goodstop");

        send_frame(8'h96, 1'b1, 1'b0, 0, 88);
        last_dout = '0;
        idle(20);
        check_frames("midreset");
        send_frame(8'h5A, 1'b1, 1'b0, 0, -1);
        idle(20);
        check_frames("after reset");

        // Break: two all-zero frames with frame_err, then the line release
        // lands inside the third frame's start cell, giving all ones.
        bus.rx = 1'b0;
        repeat (2 * L) @(negedge clk);
        push_exp('0, 1'b1, model_perr('0, 1'b0));
        push_exp('0, 1'b1, model_perr('0, 1'b0));
        push_exp('1, 1'b0, model_perr('1, 1'b1));
        idle(L + 40);
        check_frames("break");

        for (int i = 0; i < 8; i++) begin
            rd = DBIT'($urandom);
            rs = ($urandom_range(3) != 0);
`ifdef UART_RX_PARITY_EN
            rf = bit'($urandom_range(1));
`else
            rf = 1'b0;
`endif
            send_frame(rd, rs, rf, 0, -1);
            idle(30);
        end
        check_frames("random");

        tick_p = 163;
        idle(163 * 2);
`ifdef UART_RX_PARITY_EN
        send_frame(8'h81, 1'b1, 1'b1, 3, -1);
`else
        send_frame(8'h81, 1'b1, 1'b0, 3, -1);
`endif
        idle(163 * 20);
        check_frames("skew163");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
